// File: rtl/iot_pkg.sv
// Shared types and default constants for the IoT event arbiter and its round-robin picker.
package iot_pkg;

    localparam int N_DEV_DEF   = 4;
    localparam int HOLDOFF_DEF = 2;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/iot_rr_picker.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping modulo N_DEV.
module iot_rr_picker
    import iot_pkg::*;
#(
    parameter int N_DEV = N_DEV_DEF,
    parameter int IW    = (N_DEV > 1) ? $clog2(N_DEV) : 1
) (
    input  logic [N_DEV-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [N_DEV-1:0] winner_o,
    output logic [IW-1:0]    idx_o,
    output logic             any_req_o
);

    always_comb begin
        logic found;
        int   k;
        found = 1'b0;
        idx_o = '0;
        k     = 0;
        for (int i = 0; i < N_DEV; i++) begin
            k = int'(ptr_i) + i;
            if (k >= N_DEV) k = k - N_DEV;
            if (!found && req_i[k[IW-1:0]]) begin
                found = 1'b1;
                idx_o = k[IW-1:0];
            end
        end
        any_req_o = found;
        winner_o  = found ? (N_DEV'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/iot_event_arbiter.sv
// Serialises device connect/disconnect requests into change/on_off events; optional dup_count via IOT_ARB_STATS_EN.
//   state | meaning
//   IDLE  | waiting for any request; winner picked and outputs registered on leaving
//   ISSUE | one-cycle gnt (and change or dup_err) pulse
//   GAP   | hold-off after a real change, HOLDOFF cycles long
module iot_event_arbiter
    import iot_pkg::*;
#(
    parameter int N_DEV   = N_DEV_DEF,
    parameter int HOLDOFF = HOLDOFF_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_DEV-1:0] req,
    input  logic [N_DEV-1:0] req_on,
    output logic [N_DEV-1:0] gnt,
    output logic             change,
    output logic             on_off,
    output logic [N_DEV-1:0] active_map,
    output logic             dup_err
`ifdef IOT_ARB_STATS_EN
    ,
    output logic [7:0]       dup_count
`endif
);

    localparam int IW = (N_DEV > 1) ? $clog2(N_DEV) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = (HOLDOFF > 0) ? CNT_W'(HOLDOFF - 1) : '0;

    arb_state_e       state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_DEV-1:0] gnt_q, gnt_d;
    logic [N_DEV-1:0] active_q, active_d;
    logic             change_q, change_d;
    logic             on_off_q, on_off_d;
    logic             dup_err_q, dup_err_d;

    logic [N_DEV-1:0] win_onehot;
    logic [IW-1:0]    win_idx;
    logic             any_req;

    iot_rr_picker #(
        .N_DEV (N_DEV),
        .IW    (IW)
    ) u_picker (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .winner_o  (win_onehot),
        .idx_o     (win_idx),
        .any_req_o (any_req)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            active_q  <= '0;
            change_q  <= 1'b0;
            on_off_q  <= 1'b0;
            dup_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            active_q  <= active_d;
            change_q  <= change_d;
            on_off_q  <= on_off_d;
            dup_err_q <= dup_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = '0;
        active_d  = active_q;
        change_d  = 1'b0;
        on_off_d  = 1'b0;
        dup_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = ISSUE;
                    gnt_d   = win_onehot;
                    ptr_d   = (int'(win_idx) == N_DEV - 1) ? '0 : win_idx + 1'b1;
                    // Only real state changes reach the monitor; repeats are flagged instead.
                    if (req_on[win_idx] != active_q[win_idx]) begin
                        change_d          = 1'b1;
                        on_off_d          = req_on[win_idx];
                        active_d[win_idx] = req_on[win_idx];
                    end else begin
                        dup_err_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (change_q && (HOLDOFF > 0)) begin
                    state_d = GAP;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (cnt_q == '0) state_d = IDLE;
                else cnt_d = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef IOT_ARB_STATS_EN
    logic [7:0] dup_count_q;

    always_ff @(posedge clk) begin
        if (rst) dup_count_q <= '0;
        else if (dup_err_d && (dup_count_q != 8'hFF)) dup_count_q <= dup_count_q + 8'd1;
    end

    assign dup_count = dup_count_q;
`endif

    assign gnt        = gnt_q;
    assign change     = change_q;
    assign on_off     = on_off_q;
    assign active_map = active_q;
    assign dup_err    = dup_err_q;

endmodule

// File: doc/iot_event_arbiter.md
Name: iot_event_arbiter

Overview:
- Collects connect/disconnect requests from N_DEV IoT device ports and serialises them into single-cycle change/on_off events for the active-device monitor counter.
- Uses round-robin arbitration across devices.
- Keeps a per-device active bitmap and suppresses redundant events, so the monitor count stays consistent with the real device state.
- Enforces a programmable hold-off gap between issued events.

Parameters:
- N_DEV, 4, number of requesting device ports (2..16).
- HOLDOFF, 2, idle cycles forced after each issued change pulse (0..15).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- req  input  N_DEV  per-device request. Held high until the matching gnt is seen.
- req_on  input  N_DEV  per-device direction: 1 = connect, 0 = disconnect. Must be stable while req is high.
- gnt  output  N_DEV  one-hot, single-cycle acceptance pulse.
- change  output  1  event strobe to the monitor (one cycle).
- on_off  output  1  event direction to the monitor; valid when change=1, otherwise 0.
- active_map  output  N_DEV  current connected state per device.
- dup_err  output  1  single-cycle pulse when a granted request does not alter device state.

Behaviour:
- All outputs are registered. On rst: gnt=0, change=0, on_off=0, dup_err=0, active_map=0, RR pointer=0, FSM=IDLE, hold-off counter=0. Reset wins over every other event, including mid-ISSUE and mid-GAP.
- FSM states: IDLE, ISSUE, GAP.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick winner w = first set req bit at or after the RR pointer, wrapping modulo N_DEV.
  - Next cycle: go to ISSUE with gnt[w]=1.
  - RR pointer <= (w+1) mod N_DEV.
- ISSUE (exactly one cycle):
  - gnt[w]=1.
  - If req_on[w] != active_map[w] (values as sampled at the decision edge): change=1, on_off=req_on[w], active_map[w] flips in this cycle.
  - Otherwise (duplicate): change=0, on_off=0, dup_err=1, active_map unchanged.
  - req is ignored during ISSUE; the requester drops req on the edge that ends its gnt cycle.
  - Next state: GAP if change issued and HOLDOFF>0, else IDLE.
- GAP:
  - Counter loads HOLDOFF-1 on entry and decrements each cycle; return to IDLE after HOLDOFF cycles.
  - req ignored; pending requests keep waiting.
- Latency: request seen in IDLE at cycle t gives gnt/change in cycle t+1.
- Minimum event spacing: 2 cycles with HOLDOFF=0, otherwise HOLDOFF+2.
- Simultaneous requests are resolved solely by the RR pointer; no starvation, and each requester waits at most N_DEV grants.
- active_map never wraps. The monitor's wrap-around is unreachable through this block because disconnects are only forwarded for active devices.
- A req that drops before gnt is not a legal protocol; no event is generated if it is not high in IDLE.

Optional Feature:
- Macro IOT_ARB_STATS_EN.
- When defined, adds output dup_count [7:0]:
  - Increments on every dup_err pulse.
  - Saturates at 255.
  - Cleared by rst.
- When undefined, the port and its logic are absent.
- All other behaviour is identical in both builds.

Decomposition:
- Package iot_pkg holds:
  - the FSM state enum (IDLE/ISSUE/GAP), 2-bit;
  - the default constants for N_DEV and HOLDOFF;
  - the hold-off counter width constant (4).
- One sub-module, iot_rr_picker: combinational round-robin picker.
  - Inputs: req vector, pointer.
  - Outputs: one-hot winner, winner index, any_req.
- FSM, bitmap and outputs remain in iot_event_arbiter.

Test Plan:
- Reset/basic (rst high 2 cycles, then req=0001, req_on=0001):
  - gnt=0001 and change=1, on_off=1 one cycle after req.
  - active_map=0001.
  - No further events while req is low.
- Round-robin (all four req high, req_on=1111, HOLDOFF=0, pointer 0):
  - Grants 0001, 0010, 0100, 1000, each 2 cycles apart.
  - Four change pulses with on_off=1.
  - active_map=1111.
- Duplicate (device 2 active, req[2]=1 with req_on[2]=1):
  - gnt=0100, change=0, dup_err=1 for one cycle.
  - active_map unchanged.
  - With IOT_ARB_STATS_EN, dup_count goes 0 to 1.
- Disconnect and hold-off (HOLDOFF=3, active_map=0011, req[0]=1 with req_on=0, plus req[1]=1 with req_on=0 pending):
  - change=1, on_off=0, then 3 idle cycles.
  - Second event 5 cycles after the first.
  - active_map=0000.
- Reset mid-operation (rst asserted during ISSUE or GAP):
  - Next cycle all outputs 0, active_map=0, FSM IDLE.
  - After rst falls with req=1000, the grant goes to device 3 (pointer reset to 0, no lower request).
- Saturation, stats build only (300 duplicate requests): dup_count reaches 255 and holds.
